// File: rtl/trap_handle.sv
// Trap sequencer: accepts exception / mret / interrupt at commit,
// squashes the pipeline, writes trap CSRs and redirects fetch.
module trap_handle #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_except_vld,
    input  logic [5:0]      i_except_cause,
    input  logic [XLEN-1:0] i_except_pc,
    input  logic [XLEN-1:0] i_except_tval,
    input  logic            i_mret,
    input  logic [11:0]     i_irq_pend,
    input  logic            i_mie_global,
    input  logic [XLEN-1:0] i_int_pc,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_flush_done,
    output logic            o_flush,
    output logic            o_csr_we,
    output logic [XLEN-1:0] o_mcause,
    output logic [XLEN-1:0] o_mepc,
    output logic [XLEN-1:0] o_mtval,
    output logic            o_mstatus_trap,
    output logic            o_mstatus_mret,
    output logic            o_redirect_vld,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            irq_any;
    logic [3:0]      irq_code;
    logic            take_exc;
    logic            take_mret;
    logic            take_irq;
    logic            accept;

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] cause_nxt;
    logic [XLEN-1:0] epc_nxt;
    logic [XLEN-1:0] tval_nxt;
    logic [XLEN-1:0] tgt_nxt;

    logic            flush_q;
    logic            csr_we_q;
    logic            trap_q;
    logic            mret_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] target_q;

    logic            unused_bits;
    assign unused_bits = ^{i_irq_pend[10], i_irq_pend[8], i_irq_pend[6],
                           i_irq_pend[4], i_irq_pend[2], i_irq_pend[0],
                           i_mepc[0]};

    // Interrupt selection: fixed priority 11 > 3 > 7 > 9 > 1 > 5.
    always_comb begin
        irq_any  = 1'b1;
        irq_code = 4'd0;
        if (i_irq_pend[11])     irq_code = 4'd11;
        else if (i_irq_pend[3]) irq_code = 4'd3;
        else if (i_irq_pend[7]) irq_code = 4'd7;
        else if (i_irq_pend[9]) irq_code = 4'd9;
        else if (i_irq_pend[1]) irq_code = 4'd1;
        else if (i_irq_pend[5]) irq_code = 4'd5;
        else                    irq_any  = 1'b0;
    end

    // Event arbitration in IDLE: exception > mret > interrupt.
    always_comb begin
        take_exc  = (state == IDLE) && i_except_vld;
        take_mret = (state == IDLE) && !i_except_vld && i_mret;
        take_irq  = (state == IDLE) && !i_except_vld && !i_mret &&
                    i_mie_global && irq_any;
        accept    = take_exc || take_mret || take_irq;
    end

    // CSR data and redirect target captured at accept time.
    always_comb begin
        base      = {i_mtvec[XLEN-1:2], 2'b00};
        cause_nxt = XLEN'(i_except_cause);
        epc_nxt   = i_except_pc;
        tval_nxt  = i_except_tval;
        tgt_nxt   = base;
        if (take_mret) begin
            tgt_nxt = {i_mepc[XLEN-1:1], 1'b0};
        end else if (take_irq) begin
            cause_nxt = {1'b1, {(XLEN-5){1'b0}}, irq_code};
            epc_nxt   = i_int_pc;
            tval_nxt  = '0;
            if (i_mtvec[1:0] == 2'b01)
                tgt_nxt = base + (XLEN'(irq_code) << 2);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        o_busy         = 1'b0;
        o_redirect_vld = 1'b0;
        o_redirect_pc  = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FLUSH;
            end
            FLUSH: begin
                o_busy = 1'b1;
                if (i_flush_done) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                o_busy         = 1'b1;
                o_redirect_vld = 1'b1;
                o_redirect_pc  = target_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-cycle pulses after accept plus latched trap payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q  <= 1'b0;
            csr_we_q <= 1'b0;
            trap_q   <= 1'b0;
            mret_q   <= 1'b0;
            mcause_q <= '0;
            mepc_q   <= '0;
            mtval_q  <= '0;
            target_q <= '0;
        end else begin
            flush_q  <= accept;
            csr_we_q <= take_exc || take_irq;
            trap_q   <= take_exc || take_irq;
            mret_q   <= take_mret;
            if (accept) begin
                mcause_q <= cause_nxt;
                mepc_q   <= epc_nxt;
                mtval_q  <= tval_nxt;
                target_q <= tgt_nxt;
            end
        end
    end

    assign o_flush        = flush_q;
    assign o_csr_we       = csr_we_q;
    assign o_mstatus_trap = trap_q;
    assign o_mstatus_mret = mret_q;
    assign o_mcause       = mcause_q;
    assign o_mepc         = mepc_q;
    assign o_mtval        = mtval_q;

endmodule

// File: doc/trap_handle.md
TRAP_HANDLE -- requirements
Module: trap_handle

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning architectural register width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_except_vld  input  1  commit-stage oldest instruction raised an exception.
REQ-005 SHALL have port i_except_cause  input  6  exception code.
REQ-006 SHALL have port i_except_pc  input  XLEN  faulting instruction pc.
REQ-007 SHALL have port i_except_tval  input  XLEN  trap value.
REQ-008 SHALL have port i_mret  input  1  mret committing.
REQ-009 SHALL have port i_irq_pend  input  12  mip&mie, bit n = interrupt code n.
REQ-010 SHALL have port i_mie_global  input  1  mstatus.MIE.
REQ-011 SHALL have port i_int_pc  input  XLEN  pc of next instruction to commit, used as interrupt epc.
REQ-012 SHALL have port i_mtvec  input  XLEN  current mtvec.
REQ-013 SHALL have port i_mepc  input  XLEN  current mepc.
REQ-014 SHALL have port i_flush_done  input  1  backend fully drained.
REQ-015 SHALL have port o_flush  output  1  one-cycle pipeline squash pulse.
REQ-016 SHALL have port o_csr_we  output  1  one-cycle write strobe for mcause/mepc/mtval.
REQ-017 SHALL have ports o_mcause, o_mepc, o_mtval  output  XLEN each  CSR write data.
REQ-018 SHALL have port o_mstatus_trap  output  1  pulse: MPIE<=MIE, MIE<=0.
REQ-019 SHALL have port o_mstatus_mret  output  1  pulse: MIE<=MPIE, MPIE<=1.
REQ-020 SHALL have ports o_redirect_vld  output  1 and o_redirect_pc  output  XLEN  fetch redirect.
REQ-021 SHALL have port o_busy  output  1  stall commit while high.

Function
REQ-022 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-023 SHALL in IDLE accept one event per cycle, priority exception > mret > interrupt.
REQ-024 SHALL accept an interrupt only if i_mie_global=1 and any i_irq_pend bit set.
REQ-025 SHALL select interrupt code by priority 11 > 3 > 7 > 9 > 1 > 5; other bits ignored.
REQ-026 SHALL, on accept at cycle T, drive o_flush=1 for exactly cycle T+1 and enter FLUSH at T+1.
REQ-027 SHALL, for exception/interrupt, drive o_csr_we=1 and o_mstatus_trap=1 in cycle T+1 only; for mret drive o_mstatus_mret=1 in T+1 only, o_csr_we=0.
REQ-028 SHALL set o_mcause = {1'b0, zero-extended code} for exceptions, {1'b1, zero-extended code} for interrupts (bit XLEN-1 = interrupt).
REQ-029 SHALL set o_mepc = i_except_pc (exception) or i_int_pc (interrupt), latched at T.
REQ-030 SHALL set o_mtval = i_except_tval for exceptions, 0 for interrupts.
REQ-031 SHALL compute target: exception -> {mtvec[XLEN-1:2],00}; interrupt with mtvec[1:0]=01 -> base + 4*code; interrupt with mode 00/10/11 -> base; mret -> {i_mepc[XLEN-1:1],0}; sum wraps modulo 2^XLEN.
REQ-032 SHALL remain in FLUSH until i_flush_done=1 sampled, then enter REDIRECT next cycle; i_flush_done already high at T+1 permitted (REDIRECT at T+2).
REQ-033 SHALL in REDIRECT drive o_redirect_vld=1 with target for exactly one cycle, then return to IDLE.
REQ-034 SHALL hold o_busy=1 in FLUSH and REDIRECT, 0 in IDLE.
REQ-035 SHALL ignore all event inputs outside IDLE; events are not queued.
REQ-036 SHALL latch i_mtvec/i_mepc at accept; later changes do not affect target.

Reset
REQ-037 SHALL, on rst low (any state, any time), enter IDLE and drive all outputs 0 asynchronously; in-flight trap discarded.
REQ-038 SHALL accept no event in the first cycle after rst deasserts unless inputs valid at that edge (normal IDLE behaviour).

Verification
REQ-039 Exception code 2, pc 0x8000_0010, tval 0x13, mtvec 0x8000_0101 -> T+1 flush, csr_we, mcause 2, mepc 0x8000_0010, mtval 0x13; redirect 0x8000_0100.
REQ-040 i_irq_pend bits 7 and 11, MIE=1, mtvec 0x1001, int_pc 0x200 -> mcause 0x8000_0000_0000_000B, mepc 0x200, redirect 0x102C.
REQ-041 Pending irq with MIE=0 -> no accept, o_busy stays 0; same cycle exception + mret + irq -> exception only.
REQ-042 mret, mepc 0x403 -> mstatus_mret pulse, csr_we 0, redirect 0x402.
REQ-043 i_flush_done held low 5 cycles -> busy 6+ cycles, redirect one cycle after done; new exception during FLUSH ignored.
REQ-044 rst asserted in FLUSH -> immediate IDLE, all outputs 0, no redirect.
